// File: rtl/integer_retirement_tracker.sv
// Integer retirement tracker: follows each triggered integer instruction
// through DX1..DX3, reports where it retires, and flags coincident retirements.
module integer_retirement_tracker #(
    parameter int NUM_STAGES   = 3,
    parameter int TIA_OP_WIDTH = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [TIA_OP_WIDTH-1:0] issue_op,
    input  logic                    pipeline_stall,
    input  logic                    flush,
    output logic [2:0]              dx1_instruction_retiring_stage,
    output logic [2:0]              dx2_instruction_retiring_stage,
    output logic                    retire_valid,
    output logic [2:0]              retire_stage,
    output logic [TIA_OP_WIDTH-1:0] retire_op,
    output logic                    retire_collision,
    output logic                    collision_sticky,
    output logic                    issue_dropped,
    output logic [1:0]              in_flight_count
);

    // Op encodings that carry a non-unit execute latency.
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_LMUL  = TIA_OP_WIDTH'(8'h14);
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_SHMUL = TIA_OP_WIDTH'(8'h15);
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_UHMUL = TIA_OP_WIDTH'(8'h16);
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_LSW   = TIA_OP_WIDTH'(8'h1D);

    // Retiring-stage code for an op; anything not listed finishes in DX1.
    function automatic logic [2:0] latency_code(input logic [TIA_OP_WIDTH-1:0] op);
        logic [2:0] code;
        case (op)
            TIA_OP_LMUL, TIA_OP_SHMUL, TIA_OP_UHMUL: code = 3'd2;
            TIA_OP_LSW:                              code = 3'd3;
            default:                                 code = 3'd1;
        endcase
        return code;
    endfunction

    // Per-stage state; index 0 is DX1. Empty stages hold op and code at 0.
    logic [NUM_STAGES-1:0] stage_vld;
    logic [TIA_OP_WIDTH-1:0] stage_op [NUM_STAGES];
    logic [2:0]              stage_code [NUM_STAGES];
    logic [NUM_STAGES-1:0] retiring;

    // Stage advance, hold on stall, clear on flush; flush beats stall, reset beats all.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_vld[k]  <= 1'b0;
                stage_op[k]   <= '0;
                stage_code[k] <= '0;
            end
            issue_dropped    <= 1'b0;
            collision_sticky <= 1'b0;
        end else begin
            issue_dropped <= issue_valid && pipeline_stall && !flush;
            if (retire_collision) begin
                collision_sticky <= 1'b1;
            end
            if (flush || !pipeline_stall) begin
                stage_vld[0]  <= issue_valid;
                stage_op[0]   <= issue_valid ? issue_op : '0;
                stage_code[0] <= issue_valid ? latency_code(issue_op) : 3'd0;
                for (int k = 1; k < NUM_STAGES; k++) begin
                    // Occupant moves on only if it has not yet reached its retiring stage.
                    if (!flush && stage_vld[k-1] && (int'(stage_code[k-1]) > k)) begin
                        stage_vld[k]  <= 1'b1;
                        stage_op[k]   <= stage_op[k-1];
                        stage_code[k] <= stage_code[k-1];
                    end else begin
                        stage_vld[k]  <= 1'b0;
                        stage_op[k]   <= '0;
                        stage_code[k] <= '0;
                    end
                end
            end
        end
    end

    // Retirement detect: highest retiring stage wins the report, multiple ones collide.
    always_comb begin
        int n_ret;
        int n_vld;
        n_ret        = 0;
        n_vld        = 0;
        retiring     = '0;
        retire_stage = 3'd0;
        retire_op    = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            retiring[k] = !pipeline_stall && stage_vld[k] && (int'(stage_code[k]) == k + 1);
            if (retiring[k]) begin
                n_ret        = n_ret + 1;
                retire_stage = 3'(k + 1);
                retire_op    = stage_op[k];
            end
            if (stage_vld[k]) begin
                n_vld = n_vld + 1;
            end
        end
        retire_valid     = |retiring;
        retire_collision = (n_ret >= 2);
        in_flight_count  = (n_vld >= 3) ? 2'd3 : 2'(n_vld);
    end

    assign dx1_instruction_retiring_stage = stage_code[0];
    assign dx2_instruction_retiring_stage = stage_code[1];

endmodule

// File: tb/tb_integer_retirement_tracker.sv
// Randomized and directed bench for integer_retirement_tracker against a
// list-of-instructions reference model.
module tb_integer_retirement_tracker;

    localparam int W = 7;
    localparam logic [W-1:0] OP_NOP   = 7'h00;
    localparam logic [W-1:0] OP_ADD   = 7'h08;
    localparam logic [W-1:0] OP_SUB   = 7'h09;
    localparam logic [W-1:0] OP_LMUL  = 7'h14;
    localparam logic [W-1:0] OP_SHMUL = 7'h15;
    localparam logic [W-1:0] OP_UHMUL = 7'h16;
    localparam logic [W-1:0] OP_LSW   = 7'h1D;
    localparam logic [W-1:0] OP_HALT  = 7'h7F;
    localparam logic [W-1:0] OP_UNDEF = 7'h55;

    logic clock;
    logic reset;
    logic issue_valid;
    logic [W-1:0] issue_op;
    logic pipeline_stall;
    logic flush;
    logic [2:0] dx1_instruction_retiring_stage;
    logic [2:0] dx2_instruction_retiring_stage;
    logic retire_valid;
    logic [2:0] retire_stage;
    logic [W-1:0] retire_op;
    logic retire_collision;
    logic collision_sticky;
    logic issue_dropped;
    logic [1:0] in_flight_count;

    integer_retirement_tracker #(.NUM_STAGES(3), .TIA_OP_WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_op(issue_op),
        .pipeline_stall(pipeline_stall),
        .flush(flush),
        .dx1_instruction_retiring_stage(dx1_instruction_retiring_stage),
        .dx2_instruction_retiring_stage(dx2_instruction_retiring_stage),
        .retire_valid(retire_valid),
        .retire_stage(retire_stage),
        .retire_op(retire_op),
        .retire_collision(retire_collision),
        .collision_sticky(collision_sticky),
        .issue_dropped(issue_dropped),
        .in_flight_count(in_flight_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: each in-flight instruction knows its op, the stage it
    // finishes in, and the stage it currently occupies.
    typedef struct {
        int op;
        int code;
        int stage;
    } inst_t;
    inst_t q[$];
    bit m_sticky;
    bit m_dropped;

    // Values seen at the most recent sampling point.
    int obs_dx1, obs_dx2, obs_rv, obs_rs, obs_rop, obs_col, obs_sticky, obs_drop, obs_cnt;

    function automatic int ref_code(input logic [W-1:0] op);
        if (op == OP_LMUL || op == OP_SHMUL || op == OP_UHMUL) return 2;
        if (op == OP_LSW) return 3;
        return 1;
    endfunction

    task automatic step(input logic iv, input logic [W-1:0] op, input logic st,
                        input logic fl, input logic rs);
        int e1, e2, nret, rstg, rop, cnt;
        bit ecol;
        inst_t nq[$];
        inst_t ni;
        issue_valid    = iv;
        issue_op       = op;
        pipeline_stall = st;
        flush          = fl;
        reset          = rs;
        @(negedge clock);
        e1 = 0; e2 = 0; nret = 0; rstg = 0; rop = 0;
        foreach (q[i]) begin
            if (q[i].stage == 1) e1 = q[i].code;
            if (q[i].stage == 2) e2 = q[i].code;
            if (!st && q[i].stage == q[i].code) begin
                nret++;
                if (q[i].stage > rstg) begin
                    rstg = q[i].stage;
                    rop  = q[i].op;
                end
            end
        end
        ecol = (nret >= 2);
        cnt  = (q.size() > 3) ? 3 : q.size();
        chk("dx1_code", 32'(dx1_instruction_retiring_stage), 32'(e1));
        chk("dx2_code", 32'(dx2_instruction_retiring_stage), 32'(e2));
        chk("retire_valid", 32'(retire_valid), 32'(nret > 0));
        chk("retire_stage", 32'(retire_stage), 32'(rstg));
        chk("retire_op", 32'(retire_op), 32'(rop));
        chk("retire_collision", 32'(retire_collision), 32'(ecol));
        chk("collision_sticky", 32'(collision_sticky), 32'(m_sticky));
        chk("issue_dropped", 32'(issue_dropped), 32'(m_dropped));
        chk("in_flight_count", 32'(in_flight_count), 32'(cnt));
        obs_dx1 = int'(dx1_instruction_retiring_stage);
        obs_dx2 = int'(dx2_instruction_retiring_stage);
        obs_rv = int'(retire_valid);
        obs_rs = int'(retire_stage);
        obs_rop = int'(retire_op);
        obs_col = int'(retire_collision);
        obs_sticky = int'(collision_sticky);
        obs_drop = int'(issue_dropped);
        obs_cnt = int'(in_flight_count);
        @(posedge clock);
        ni.op = int'(op);
        ni.code = ref_code(op);
        ni.stage = 1;
        if (rs) begin
            q.delete();
            m_sticky  = 0;
            m_dropped = 0;
        end else begin
            m_dropped = iv && st && !fl;
            if (ecol) m_sticky = 1;
            if (fl) begin
                q.delete();
                if (iv) q.push_back(ni);
            end else if (!st) begin
                foreach (q[i]) begin
                    if (q[i].stage != q[i].code) begin
                        nq.push_back(q[i]);
                        nq[nq.size()-1].stage = q[i].stage + 1;
                    end
                end
                if (iv) nq.push_back(ni);
                q = nq;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, OP_NOP, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [W-1:0] op);
        step(1'b1, op, 1'b0, 1'b0, 1'b0);
    endtask

    logic [W-1:0] op_pool [9];

    initial begin
        op_pool = '{OP_NOP, OP_ADD, OP_SUB, OP_LMUL, OP_SHMUL, OP_UHMUL, OP_LSW, OP_HALT, OP_UNDEF};
        reset = 1'b1; issue_valid = 1'b0; issue_op = '0; pipeline_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        q.delete(); m_sticky = 0; m_dropped = 0;

        // Reset state
        step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1);
        idle();
        chk("rst_count", obs_cnt, 0);
        chk("rst_retire", obs_rv, 0);

        // Single-cycle ADD
        issue(OP_ADD);
        idle();
        chk("add_dx1", obs_dx1, 1);
        chk("add_rv", obs_rv, 1);
        chk("add_rs", obs_rs, 1);
        chk("add_rop", obs_rop, OP_ADD);
        idle();
        chk("add_after_rv", obs_rv, 0);
        chk("add_after_dx1", obs_dx1, 0);

        // LMUL retires from DX2
        issue(OP_LMUL);
        idle();
        chk("lmul_dx1", obs_dx1, 2);
        chk("lmul_rv_early", obs_rv, 0);
        idle();
        chk("lmul_dx2", obs_dx2, 2);
        chk("lmul_rv", obs_rv, 1);
        chk("lmul_rs", obs_rs, 2);

        // LMUL then ADD collide
        issue(OP_LMUL);
        issue(OP_ADD);
        idle();
        chk("col_flag", obs_col, 1);
        chk("col_rs", obs_rs, 2);
        chk("col_rop", obs_rop, OP_LMUL);
        idle();
        chk("col_sticky", obs_sticky, 1);
        step(1'b0, OP_NOP, 1'b0, 1'b0, 1'b1);

        // LSW delayed by two stall cycles, with a dropped issue
        issue(OP_LSW);
        idle();
        step(1'b1, OP_ADD, 1'b1, 1'b0, 1'b0);
        chk("stall_cnt0", obs_cnt, 1);
        chk("stall_rv", obs_rv, 0);
        step(1'b0, OP_NOP, 1'b1, 1'b0, 1'b0);
        chk("stall_drop", obs_drop, 1);
        chk("stall_cnt1", obs_cnt, 1);
        idle();
        chk("stall_rv_t4", obs_rv, 0);
        chk("stall_drop_end", obs_drop, 0);
        idle();
        chk("stall_rv_t5", obs_rv, 1);
        chk("stall_rs_t5", obs_rs, 3);
        chk("stall_rop_t5", obs_rop, OP_LSW);

        // Flush with ADD issued while LSW and LMUL are in flight
        issue(OP_LSW);
        issue(OP_LMUL);
        step(1'b1, OP_ADD, 1'b0, 1'b1, 1'b0);
        chk("flush_cnt_before", obs_cnt, 2);
        idle();
        chk("flush_dx1", obs_dx1, 1);
        chk("flush_dx2", obs_dx2, 0);
        chk("flush_cnt", obs_cnt, 1);
        chk("flush_rs", obs_rs, 1);
        repeat (3) begin
            idle();
            chk("flush_no_retire", obs_rv, 0);
        end

        // Reset while LSW sits in DX2, after setting the sticky flag
        issue(OP_LMUL);
        issue(OP_ADD);
        issue(OP_LSW);
        idle();
        step(1'b0, OP_NOP, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_sticky_before", obs_sticky, 1);
        chk("rst_mid_dx2_before", obs_dx2, 3);
        idle();
        chk("rst_mid_dx2", obs_dx2, 0);
        chk("rst_mid_cnt", obs_cnt, 0);
        chk("rst_mid_sticky", obs_sticky, 0);
        chk("rst_mid_rv", obs_rv, 0);
        idle();
        chk("rst_mid_rv_late", obs_rv, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic iv, st, fl, rs;
            logic [W-1:0] op;
            iv = ($urandom_range(99) < 60);
            st = ($urandom_range(99) < 20);
            fl = ($urandom_range(99) < 5);
            rs = ($urandom_range(99) < 2);
            op = op_pool[$urandom_range(8)];
            step(iv, op, st, fl, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
